// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises and edge-detects IRQ lines, tracks pending and
// in-service levels, and reports the highest-priority request and handler vector.
module intr_ctrl #(
    parameter int unsigned   N          = 8,
    parameter int unsigned   AW         = 10,
    parameter logic [AW-1:0] VEC_BASE   = 10'h3C0,
    parameter int unsigned   VEC_STRIDE = 4,
    parameter logic [N-1:0]  MASK_RST   = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  irq,
    input  logic          mask_we,
    input  logic [N-1:0]  mask_din,
    input  logic [N-1:0]  s_call_intr,
    input  logic [N-1:0]  s_return_intr,
    output logic [N-1:0]  min_bit_s,
    output logic [N-1:0]  min_bit_a,
    output logic [AW-1:0] intr_vec,
    output logic [N-1:0]  pend,
    output logic [N-1:0]  isr,
    output logic          call_err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;
    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] isr_q, isr_d;
    logic [N-1:0] mask_q, mask_d;
    logic         call_err_q, call_err_d;

    logic [N-1:0]  rise;
    logic [N-1:0]  call;
    logic [N-1:0]  ret;
    logic          call_ok;
    logic          ret_ok;
    logic [N-1:0]  masked;
    logic [IW-1:0] idx_s;

    function automatic logic is_one_hot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;

        // Malformed strobes from uc are dropped rather than partially applied.
        call_ok = is_one_hot(s_call_intr);
        ret_ok  = is_one_hot(s_return_intr);
        call    = call_ok ? s_call_intr : '0;
        ret     = ret_ok ? s_return_intr : '0;

        pend_d     = rise | (pend_q & ~call);
        isr_d      = call | (isr_q & ~ret);
        mask_d     = mask_we ? mask_din : mask_q;
        call_err_d = call_err_q
                   | ((|s_call_intr) & ~call_ok)
                   | ((|s_return_intr) & ~ret_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            pend_q     <= '0;
            isr_q      <= '0;
            mask_q     <= MASK_RST;
            call_err_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            isr_q      <= isr_d;
            mask_q     <= mask_d;
            call_err_q <= call_err_d;
        end
    end

    always_comb begin
        masked    = pend_q & mask_q;
        // Two's-complement trick isolates the lowest set bit.
        min_bit_s = masked & (~masked + N'(1));
        min_bit_a = isr_q & (~isr_q + N'(1));

        idx_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                idx_s = IW'(i);
            end
        end
        intr_vec = VEC_BASE + AW'(idx_s * VEC_STRIDE);
    end

    assign pend     = pend_q;
    assign isr      = isr_q;
    assign call_err = call_err_q;

endmodule
